logic_op_unit: RTL and testbench
================================

# logic_op_unit

Parametrised, registered successor to the two-key selectable gate (AND/NAND/OR/NOR). It applies one of eight bitwise operations to WIDTH-bit operands behind a valid/ready handshake. An optional accumulate mode feeds the previous result back as operand B. The block sits between the switch/operand front end and the display/result stage of the logic-exercise datapath and also counts completed operations.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 8, width of the completed-operation counter (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when acc=1)
- op  in  3  operation select; op[1:0] keeps the legacy {chave1,chave2} coding
- acc  in  1  use accumulator register as operand B
- clr_acc  in  1  clear accumulator (see Operation)
- out_valid  out  1  result held in y
- out_ready  in  1  downstream takes result
- y  out  WIDTH  registered result
- zero  out  1  y == 0
- ones  out  1  y == all ones
- count  out  CNT_W  number of accepted transfers, modulo 2^CNT_W

## Operation
- Op codes:
  - 000 AND, 001 NAND, 010 OR, 011 NOR
  - 100 XOR, 101 XNOR, 110 NOT a, 111 PASS a
- Effective B is selected as follows:
  - acc=0: b
  - acc=1, clr_acc=0: acc_reg
  - acc=1, clr_acc=1: 0
- Accept condition: in_valid && in_ready, with in_ready = !out_valid || out_ready (one-entry output register, combinational ready).
- On accept:
  - y <= f(op, a, Beff)
  - acc_reg <= same result
  - out_valid <= 1
  - count <= count+1, wrapping from 2^CNT_W−1 to 0
- Result consumed (out_valid && out_ready) with no accept in the same cycle: out_valid <= 0; y and acc_reg keep their values.
- Accept and consume in the same cycle: a new result is loaded and out_valid stays 1. Full throughput is one result per cycle.
- clr_acc with no accept: acc_reg <= 0. clr_acc with an accept: the rule above applies, and acc_reg loads the new result.
- Stall (out_valid=1, out_ready=0): y, zero, ones and count are held stable and in_ready=0. Inputs are don't-care.
- zero and ones are registered alongside y and are always consistent with y.
- Reset values: y=0, acc_reg=0, out_valid=0, count=0, zero=1, ones=0 (ones=1 only when WIDTH… never, since y=0). in_ready=1 once out of reset.

## Timing
- Latency: 1 cycle from accept edge to out_valid=1 with y valid.
- in_ready depends combinationally on out_valid and out_ready only, never on in_valid.
- Asserting rst_n low mid-operation immediately (asynchronously) clears out_valid, y, acc_reg and count. Any in-flight result is discarded.
- Reset release is synchronised externally. The first accept is possible on the first rising edge with rst_n=1.
- Sampling order within an edge: acc_reg is read before it is updated, so back-to-back accumulate operations chain correctly at one per cycle.

## Structure
- Shared package logic_op_pkg holds:
  - the op-code localparams (OP_AND … OP_PASS)
  - OP_W = 3
- Sub-module logic_op_core (purely combinational): inputs op, a, beff; output result. It is parametrised by WIDTH and is reused by the legacy two-key wrapper, with op[2] tied to 0.
- Top level holds the handshake register, acc_reg, flag registers and counter.

## Test plan
- Reset, then drive a=8'hA5, b=8'h0F, acc=0 through ops 000..111 with out_ready=1. Expect y = 05, FA, AF, 50, AA, 55, 5A, A5 on consecutive cycles and count=8.
- Accumulate: clr_acc=1 with acc=1, op=OR, a=01; then acc=1, a=02, 04, 80. Expect y = 01, 03, 07, 87, and acc_reg tracks y.
- Backpressure: send op=AND, a=FF, b=3C, hold out_ready=0 for 5 cycles. Expect y=3C stable, in_ready=0 and count unchanged. Release out_ready and check that exactly one consume occurs.
- Flags: a=00, op=PASS gives zero=1, ones=0. a=00, op=NOT gives zero=0, ones=1. a=FF, b=FF, op=XOR gives zero=1.
- Counter wrap with CNT_W=2: 5 accepts leave count=1.
- Reset mid-stream: pull rst_n low while out_valid=1 and acc_reg=87. Expect y=0, out_valid=0 and count=0 immediately. After release, an acc=1 OR with a=01 gives y=01.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared op-code definitions for the logic-exercise datapath.
// op[1:0] keeps the legacy two-key {chave1,chave2} coding; op[2] selects the extended ops.
package logic_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_NAND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: result = f(op, a, beff). Zero latency, no handshake.
// Shared with the legacy two-key wrapper, which ties op[2] to 0.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] beff,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_AND:  result = a & beff;
      OP_NAND: result = ~(a & beff);
      OP_OR:   result = a | beff;
      OP_NOR:  result = ~(a | beff);
      OP_XOR:  result = a ^ beff;
      OP_XNOR: result = ~(a ^ beff);
      OP_NOT:  result = ~a;
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/logic_op_unit.sv
// Registered bitwise op unit with optional accumulate and completed-op counter; 1-cycle latency.
// One-entry output register: in_ready = !out_valid || out_ready, so a held result stalls input.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             consume;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // acc_reg is read here before the edge updates it, so accumulate chains at full rate.
  always_comb begin
    beff = b;
    if (acc) begin
      beff = clr_acc ? '0 : acc_reg;
    end
  end

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .beff   (beff),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      acc_reg   <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
    end else if (accept) begin
      y         <= result;
      acc_reg   <= result;
      out_valid <= 1'b1;
      count     <= count + CNT_W'(1);
      zero      <= (result == '0);
      ones      <= &result;
    end else begin
      if (consume) begin
        out_valid <= 1'b0;
      end
      if (clr_acc) begin
        acc_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit: driver pushes expected results, negedge monitor pops and compares.
module tb_logic_op_unit;
  import logic_op_pkg::*;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic [7:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_ready2;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc, clr_acc;
  logic       out_valid, out_valid2, out_ready;
  logic [7:0] y, y2;
  logic       zero, ones, zero2, ones2;
  logic [7:0] count;
  logic [1:0] count2;

  exp_t       q[$];
  logic [7:0] acc_m;
  logic [7:0] cnt_m;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  logic_op_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc(acc), .clr_acc(clr_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .count(count)
  );

  logic_op_unit #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .acc(acc), .clr_acc(clr_acc),
    .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .zero(zero2), .ones(ones2), .count(count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  // Reference: each op is a 2-input truth table indexed by {a_bit, beff_bit}.
  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] v);
    logic [3:0] tt [8];
    logic [3:0] t;
    logic [7:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b0111; tt[2] = 4'b1110; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    t = tt[o];
    for (int i = 0; i < 8; i++) r[i] = t[{x[i], v[i]}];
    return r;
  endfunction

  task automatic cycle(input logic iv, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [2:0] top, input logic tacc, input logic tclr, input logic tordy);
    exp_t       e;
    logic [7:0] beff, r;
    @(posedge clk);
    #2;
    in_valid = iv; a = ta; b = tb_v; op = top; acc = tacc; clr_acc = tclr; out_ready = tordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    chk("in_ready2", 32'(in_ready2), 32'(!out_valid || out_ready));
    if (iv && in_ready) begin
      beff  = !tacc ? tb_v : (tclr ? 8'h00 : acc_m);
      r     = ref_op(top, ta, beff);
      acc_m = r;
      cnt_m = cnt_m + 8'd1;
      e.y = r; e.z = (r == 8'h00); e.o = (r == 8'hFF); e.c = cnt_m;
      q.push_back(e);
    end else if (tclr) begin
      acc_m = 8'h00;
    end
  endtask

  task automatic idle(input logic tordy);
    cycle(1'b0, 8'h00, 8'h00, OP_AND, 1'b0, 1'b0, tordy);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(y), 32'hFFFF_FFFF);
      end else begin
        chk("y", 32'(y), 32'(q[0].y));
        chk("zero", 32'(zero), 32'(q[0].z));
        chk("ones", 32'(ones), 32'(q[0].o));
        chk("count", 32'(count), 32'(q[0].c));
        chk("out_valid2", 32'(out_valid2), 32'd1);
        chk("y2", 32'(y2), 32'(q[0].y));
        chk("count2", 32'(count2), 32'(q[0].c[1:0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; acc = 1'b0; clr_acc = 1'b0; out_ready = 1'b0;
    acc_m = '0; cnt_m = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_y", 32'(y), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ones", 32'(ones), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // All eight ops on A5/0F, full throughput.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("ops_last_y", 32'(y), 32'hA5);
    chk("ops_count8", 32'(count), 32'd8);
    idle(1'b1);

    // Accumulate chain 01, 03, 07, 87.
    cycle(1'b1, 8'h01, 8'h5A, OP_OR, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h02, 8'h5A, OP_OR, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h04, 8'h5A, OP_OR, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 8'h5A, OP_OR, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("acc_y87", 32'(y), 32'h87);
    idle(1'b1);

    // Backpressure.
    cycle(1'b1, 8'hFF, 8'h3C, OP_AND, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h12, 8'h34, OP_XOR, 1'b0, 1'b0, 1'b0);
      chk("stall_y", 32'(y), 32'h3C);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_count", 32'(count), 32'(cnt_m));
    end
    idle(1'b1);
    chk("release_out_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    chk("one_consume_out_valid", 32'(out_valid), 32'd0);
    chk("one_consume_q", 32'(q.size()), 32'd0);

    // Flags.
    cycle(1'b1, 8'h00, 8'h00, OP_PASS, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("flag_pass_zero", 32'(zero), 32'd1);
    chk("flag_pass_ones", 32'(ones), 32'd0);
    cycle(1'b1, 8'h00, 8'h00, OP_NOT, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("flag_not_zero", 32'(zero), 32'd0);
    chk("flag_not_ones", 32'(ones), 32'd1);
    cycle(1'b1, 8'hFF, 8'hFF, OP_XOR, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("flag_xor_zero", 32'(zero), 32'd1);

    // Random traffic, long enough to wrap the 8-bit counter.
    for (int i = 0; i < 700; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 7));
    end
    repeat (3) idle(1'b1);
    chk("drain_q", 32'(q.size()), 32'd0);

    // Reset mid-stream while holding 87.
    cycle(1'b1, 8'h01, 8'h00, OP_OR, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h02, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h04, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    chk("pre_rst_y", 32'(y), 32'h87);
    #1;
    rst_n = 1'b0;
    q.delete();
    acc_m = '0;
    cnt_m = '0;
    #1;
    chk("midrst_y", 32'(y), 32'h00);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    chk("midrst_count2", 32'(count2), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycle(1'b1, 8'h01, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("post_rst_acc_y", 32'(y), 32'h01);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("wrap_count5", 32'(count), 32'd5);
    chk("wrap_count2", 32'(count2), 32'd1);
    repeat (2) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
